// File: rtl/plot_pkg.sv
// Shared types and screen constants for the pixel-plot receiver.
package plot_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int FB_AW    = 15;

    typedef logic [2:0] colour_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        colour_t    colour;
    } plot_req_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Row-major linear framebuffer address; legal coordinates never overflow FB_AW bits.
    function automatic logic [FB_AW-1:0] lin_addr(input logic [7:0] px,
                                                  input logic [6:0] py,
                                                  input int unsigned w);
        return FB_AW'(32'(py) * w + 32'(px));
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot requests. Push is ignored when full and pop when
// empty, so the caller may drive them without extra guarding.
module plot_fifo
    import plot_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      clock,
    input  logic      resetn,
    input  logic      push_i,
    input  plot_req_t wdata_i,
    input  logic      pop_i,
    output plot_req_t rdata_o,
    output logic      full_o,
    output logic      empty_o,
    output logic [AW:0] count_o
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    plot_req_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Storage array: written on accepted pushes only, contents need no reset.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/plot_receiver.sv
// Pixel-plot receiver: accepts (x, y, colour) requests, clips off-screen ones,
// buffers the rest and writes them into the shared framebuffer port when the
// scan-out side grants a slot. Optional full-screen clear is built only when
// PLOT_RECEIVER_CLEAR_EN is defined.
module plot_receiver
    import plot_pkg::*;
#(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    output logic        plot_ready,
    input  logic        clear_req,
    input  logic [2:0]  clear_colour,
    output logic        clear_busy,
    input  logic        fb_gnt,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic [7:0]  drop_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] X_LIM    = 8'(WIDTH);
    localparam logic [6:0] Y_LIM    = 7'(HEIGHT);
    localparam logic [7:0] DROP_MAX = 8'd255;

    plot_req_t         head_s;
    plot_req_t         wreq_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic              accept_s;
    logic              in_range_s;
    logic              push_s;
    logic              pop_s;
    logic              plot_ready_s;
    logic              clear_busy_s;
    logic              sweep_wr_s;
    logic [FB_AW-1:0]  sweep_addr_s;
    colour_t           sweep_colour_s;

    logic              fb_we_q,    fb_we_d;
    logic [FB_AW-1:0]  fb_addr_q,  fb_addr_d;
    colour_t           fb_data_q,  fb_data_d;
    logic [7:0]        drop_q,     drop_d;

    logic              unused_count_s;

    assign accept_s   = plot && plot_ready_s;
    assign in_range_s = (x < X_LIM) && (y < Y_LIM);
    assign push_s     = accept_s && in_range_s;
    assign pop_s      = !fifo_empty_s && fb_gnt;
    assign wreq_s     = '{x: x, y: y, colour: colour};
    assign unused_count_s = ^fifo_count_s;

    plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push_i  (push_s),
        .wdata_i (wreq_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

`ifdef PLOT_RECEIVER_CLEAR_EN
    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(WIDTH * HEIGHT - 1);
    localparam logic [FB_AW-1:0] ADDR_ONE  = FB_AW'(1);

    state_t            state_q,      state_d;
    logic [FB_AW-1:0]  clr_cnt_q,    clr_cnt_d;
    colour_t           clr_colour_q, clr_colour_d;

    // FSM state, clear address counter and latched fill colour.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RUN;
            clr_cnt_q    <= '0;
            clr_colour_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_colour_q <= clr_colour_d;
        end
    end

    // Next state: drain buffered plots (and the last write) before sweeping.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clr_colour_d = clr_colour_q;
        case (state_q)
            RUN: begin
                clr_cnt_d = '0;
                if (clear_req) begin
                    state_d      = DRAIN;
                    clr_colour_d = clear_colour;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (fifo_empty_s && !fb_we_q) begin
                    state_d = CLEAR;
                end else begin
                    state_d = DRAIN;
                end
            end
            CLEAR: begin
                if (fb_gnt) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d   = RUN;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_ONE;
                    end
                end else begin
                    clr_cnt_d = clr_cnt_q;
                end
            end
            default: begin
                state_d   = RUN;
                clr_cnt_d = '0;
            end
        endcase
    end

    // State-decoded outputs: handshake readiness, busy flag and sweep write strobe.
    always_comb begin
        plot_ready_s = 1'b0;
        clear_busy_s = 1'b0;
        sweep_wr_s   = 1'b0;
        case (state_q)
            RUN:   plot_ready_s = !fifo_full_s;
            DRAIN: clear_busy_s = 1'b1;
            CLEAR: begin
                clear_busy_s = 1'b1;
                sweep_wr_s   = fb_gnt;
            end
            default: plot_ready_s = 1'b0;
        endcase
    end

    assign sweep_addr_s   = clr_cnt_q;
    assign sweep_colour_s = clr_colour_q;
`else
    logic unused_clear_s;

    assign unused_clear_s = clear_req ^ (^clear_colour);
    assign plot_ready_s   = !fifo_full_s;
    assign clear_busy_s   = 1'b0;
    assign sweep_wr_s     = 1'b0;
    assign sweep_addr_s   = '0;
    assign sweep_colour_s = 3'd0;
`endif

    // Framebuffer write port: buffered plots first, then sweep writes; hold when idle.
    always_comb begin
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        if (pop_s) begin
            fb_we_d   = 1'b1;
            fb_addr_d = lin_addr(head_s.x, head_s.y, WIDTH);
            fb_data_d = head_s.colour;
        end else if (sweep_wr_s) begin
            fb_we_d   = 1'b1;
            fb_addr_d = sweep_addr_s;
            fb_data_d = sweep_colour_s;
        end else begin
            fb_we_d = 1'b0;
        end
    end

    // Saturating count of clipped (accepted but discarded) requests.
    always_comb begin
        if (accept_s && !in_range_s && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Registered framebuffer outputs and drop counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= 3'd0;
            drop_q    <= 8'd0;
        end else begin
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            drop_q    <= drop_d;
        end
    end

    assign plot_ready = plot_ready_s;
    assign clear_busy = clear_busy_s;
    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_plot_receiver.sv
// Directed, table-driven bench for plot_receiver. Clear-path sequences are
// compiled in when PLOT_RECEIVER_CLEAR_EN is defined; otherwise the bench
// checks that clear requests are ignored.
module tb_plot_receiver;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        plot = 1'b0;
    logic [7:0]  x = 8'd0;
    logic [6:0]  y = 7'd0;
    logic [2:0]  colour = 3'd0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_colour = 3'd0;
    logic        fb_gnt = 1'b0;
    logic        plot_ready;
    logic        clear_busy;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic [7:0]  drop_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        plot;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  colour;
        logic        gnt;
        logic        e_ready;
        logic        e_we;
        logic [14:0] e_addr;
        logic [2:0]  e_data;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs [13];

    plot_receiver dut (
        .clock        (clock),
        .resetn       (resetn),
        .plot         (plot),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot_ready   (plot_ready),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .fb_gnt       (fb_gnt),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .drop_count   (drop_count)
    );

    always #10 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, plot_ready}, 32'd1);
        chk({tag, "_we"},    {31'd0, fb_we}, 32'd0);
        chk({tag, "_addr"},  {17'd0, fb_addr}, 32'd0);
        chk({tag, "_data"},  {29'd0, fb_data}, 32'd0);
        chk({tag, "_busy"},  {31'd0, clear_busy}, 32'd0);
        chk({tag, "_drop"},  {24'd0, drop_count}, 32'd0);
    endtask

    initial begin
        int idx;
        int errs;
        int busy_errs;
        int cycles;
        int wr_cnt;
        logic pulsed;

        // plot, x, y, colour, gnt | ready, we, addr, data, drop (after the edge)
        vecs[0]  = '{1'b1, 8'd30,  7'd110, 3'b100, 1'b1, 1'b1, 1'b0, 15'd0,     3'd0, 8'd0};
        vecs[1]  = '{1'b0, 8'd0,   7'd0,   3'd0,   1'b1, 1'b1, 1'b1, 15'd17630, 3'd4, 8'd0};
        vecs[2]  = '{1'b0, 8'd0,   7'd0,   3'd0,   1'b1, 1'b1, 1'b0, 15'd17630, 3'd4, 8'd0};
        vecs[3]  = '{1'b1, 8'd160, 7'd5,   3'd1,   1'b1, 1'b1, 1'b0, 15'd17630, 3'd4, 8'd1};
        vecs[4]  = '{1'b1, 8'd0,   7'd120, 3'd1,   1'b1, 1'b1, 1'b0, 15'd17630, 3'd4, 8'd2};
        vecs[5]  = '{1'b1, 8'd159, 7'd119, 3'd7,   1'b0, 1'b1, 1'b0, 15'd17630, 3'd4, 8'd2};
        vecs[6]  = '{1'b1, 8'd0,   7'd0,   3'd2,   1'b1, 1'b1, 1'b1, 15'd19199, 3'd7, 8'd2};
        vecs[7]  = '{1'b0, 8'd0,   7'd0,   3'd0,   1'b1, 1'b1, 1'b1, 15'd0,     3'd2, 8'd2};
        vecs[8]  = '{1'b0, 8'd0,   7'd0,   3'd0,   1'b1, 1'b1, 1'b0, 15'd0,     3'd2, 8'd2};
        vecs[9]  = '{1'b1, 8'd1,   7'd1,   3'd5,   1'b1, 1'b1, 1'b0, 15'd0,     3'd2, 8'd2};
        vecs[10] = '{1'b0, 8'd0,   7'd0,   3'd0,   1'b0, 1'b1, 1'b0, 15'd0,     3'd2, 8'd2};
        vecs[11] = '{1'b0, 8'd0,   7'd0,   3'd0,   1'b1, 1'b1, 1'b1, 15'd161,   3'd5, 8'd2};
        vecs[12] = '{1'b0, 8'd0,   7'd0,   3'd0,   1'b0, 1'b1, 1'b0, 15'd161,   3'd5, 8'd2};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk_reset_vals("reset");
        @(negedge clock);
        resetn = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 13; i++) begin
            plot   = vecs[i].plot;
            x      = vecs[i].x;
            y      = vecs[i].y;
            colour = vecs[i].colour;
            fb_gnt = vecs[i].gnt;
            tick();
            chk($sformatf("vec%0d_ready", i), {31'd0, plot_ready}, {31'd0, vecs[i].e_ready});
            chk($sformatf("vec%0d_we", i),    {31'd0, fb_we},      {31'd0, vecs[i].e_we});
            chk($sformatf("vec%0d_addr", i),  {17'd0, fb_addr},    {17'd0, vecs[i].e_addr});
            chk($sformatf("vec%0d_data", i),  {29'd0, fb_data},    {29'd0, vecs[i].e_data});
            chk($sformatf("vec%0d_drop", i),  {24'd0, drop_count}, {24'd0, vecs[i].e_drop});
        end
        plot = 1'b0;

        // FIFO full: 9 back-to-back plots with no grant
        fb_gnt = 1'b0;
        for (int i = 0; i < 9; i++) begin
            plot   = 1'b1;
            x      = 8'(i * 3);
            y      = 7'(i + 40);
            colour = 3'(i);
            chk($sformatf("full_ready%0d", i), {31'd0, plot_ready}, (i < 8) ? 32'd1 : 32'd0);
            tick();
        end
        chk("full_no_we", {31'd0, fb_we}, 32'd0);
        plot   = 1'b0;
        fb_gnt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("drain%0d_we", k),   {31'd0, fb_we},   32'd1);
            chk($sformatf("drain%0d_addr", k), {17'd0, fb_addr}, 32'((k + 40) * 160 + k * 3));
            chk($sformatf("drain%0d_data", k), {29'd0, fb_data}, 32'(k));
        end
        chk("drain_ready", {31'd0, plot_ready}, 32'd1);
        tick();
        chk("drain_idle_we", {31'd0, fb_we}, 32'd0);

        // Clipping saturation
        fb_gnt = 1'b0;
        plot   = 1'b1;
        x      = 8'd200;
        y      = 7'd0;
        repeat (10) tick();
        chk("drop_mid", {24'd0, drop_count}, 32'd12);
        repeat (290) tick();
        plot = 1'b0;
        chk("drop_sat", {24'd0, drop_count}, 32'd255);
        chk("drop_no_we", {31'd0, fb_we}, 32'd0);
        chk("drop_ready", {31'd0, plot_ready}, 32'd1);

`ifdef PLOT_RECEIVER_CLEAR_EN
        // Three queued plots, the last one on the clear_req edge, then full clear
        fb_gnt = 1'b0;
        plot = 1'b1; x = 8'd10; y = 7'd10; colour = 3'd1;
        tick();
        x = 8'd11; colour = 3'd2;
        tick();
        x = 8'd12; colour = 3'd3; clear_req = 1'b1; clear_colour = 3'd0;
        tick();
        plot = 1'b0; clear_req = 1'b0;
        chk("clr_busy_start", {31'd0, clear_busy}, 32'd1);
        chk("clr_ready_start", {31'd0, plot_ready}, 32'd0);
        fb_gnt = 1'b1;
        idx = 0; errs = 0; busy_errs = 0; pulsed = 1'b0;
        for (int c = 0; c < 19400 && idx < 19203; c++) begin
            tick();
            if (fb_we) begin
                if (idx < 3) begin
                    if (fb_addr !== 15'(1610 + idx) || fb_data !== 3'(idx + 1)) begin
                        if (errs == 0) $display("FAIL clr_plot_write: actual=%0d/%0d required=%0d/%0d", fb_addr, fb_data, 1610 + idx, idx + 1);
                        errs++;
                    end
                end else if (fb_addr !== 15'(idx - 3) || fb_data !== 3'd0) begin
                    if (errs == 0) $display("FAIL clr_sweep_write: actual=%0d/%0d required=%0d/0", fb_addr, fb_data, idx - 3);
                    errs++;
                end
                idx++;
            end
            if (idx < 19203 && clear_busy !== 1'b1) busy_errs++;
            if (idx == 100 && !pulsed) begin
                clear_req = 1'b1; clear_colour = 3'd7; pulsed = 1'b1;
            end else begin
                clear_req = 1'b0;
            end
        end
        chk("clr_seq_errs", 32'(errs), 32'd0);
        chk("clr_busy_errs", 32'(busy_errs), 32'd0);
        chk("clr_write_count", 32'(idx), 32'd19203);
        chk("clr_busy_end", {31'd0, clear_busy}, 32'd0);
        chk("clr_ready_end", {31'd0, plot_ready}, 32'd1);
        tick();
        chk("clr_idle_we", {31'd0, fb_we}, 32'd0);

        // Clear with grant toggling every cycle
        fb_gnt = 1'b0; clear_req = 1'b1; clear_colour = 3'd5;
        tick();
        clear_req = 1'b0;
        idx = 0; errs = 0; cycles = 0;
        for (int c = 0; c < 40000; c++) begin
            fb_gnt = ~fb_gnt;
            tick();
            if (fb_we) begin
                if (fb_addr !== 15'(idx) || fb_data !== 3'd5) begin
                    if (errs == 0) $display("FAIL tog_write: actual=%0d/%0d required=%0d/5", fb_addr, fb_data, idx);
                    errs++;
                end
                idx++;
            end
            if (clear_busy) cycles++;
            else break;
        end
        chk("tog_errs", 32'(errs), 32'd0);
        chk("tog_count", 32'(idx), 32'd19200);
        chk("tog_cycles", 32'(cycles), 32'd38400);

        // Reset in the middle of a clear
        fb_gnt = 1'b1; clear_req = 1'b1; clear_colour = 3'd6;
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            tick();
            if (fb_we && fb_addr == 15'd5000) break;
        end
        chk("rst_reach", {17'd0, fb_addr}, 32'd5000);
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        @(negedge clock);
        resetn = 1'b1;
        plot = 1'b1; x = 8'd5; y = 7'd5; colour = 3'd6;
        tick();
        plot = 1'b0;
        tick();
        chk("post_rst_we", {31'd0, fb_we}, 32'd1);
        chk("post_rst_addr", {17'd0, fb_addr}, 32'd805);
        chk("post_rst_data", {29'd0, fb_data}, 32'd6);
        chk("post_rst_busy", {31'd0, clear_busy}, 32'd0);
        tick();
        chk("post_rst_idle", {31'd0, fb_we}, 32'd0);
`else
        // Clear disabled: clear_req is ignored and plots continue normally
        fb_gnt = 1'b1; clear_req = 1'b1; clear_colour = 3'd7;
        plot = 1'b1; x = 8'd2; y = 7'd3; colour = 3'd1;
        tick();
        clear_req = 1'b0; plot = 1'b0;
        chk("noclr_busy", {31'd0, clear_busy}, 32'd0);
        chk("noclr_ready", {31'd0, plot_ready}, 32'd1);
        tick();
        chk("noclr_we", {31'd0, fb_we}, 32'd1);
        chk("noclr_addr", {17'd0, fb_addr}, 32'd482);
        chk("noclr_data", {29'd0, fb_data}, 32'd1);
        wr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (fb_we) wr_cnt++;
        end
        chk("noclr_no_sweep", 32'(wr_cnt), 32'd0);
        chk("noclr_busy_end", {31'd0, clear_busy}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
